// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } div_state_e;

  // Every quotient bit is set when the divisor is zero.
  localparam logic DBZ_QUOTIENT_BIT = 1'b1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on magnitudes.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] a_shift_s;
  logic [WIDTH:0] trial_s;

  // The partial remainder stays below d, so the shifted value and the
  // trial difference both fit in WIDTH+1 bits with a meaningful sign bit.
  assign a_shift_s = {a, q[WIDTH-1]};
  assign trial_s   = a_shift_s - {1'b0, d};
  assign a_next    = trial_s[WIDTH] ? a_shift_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
  assign q_next    = {q[WIDTH-2:0], ~trial_s[WIDTH]};

endmodule

// File: rtl/div_seq_param.sv
// Sequential restoring divider, one quotient bit per cycle, z = {rem, quo}.
// Signed operation is only built when DIV_SIGNED_EN is defined.
module div_seq_param
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] z
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1'b1);

  div_state_e       state_r;
  div_state_e       state_next_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    count_r;
  logic             dvd_neg_r;
  logic             dvs_neg_r;
  logic             dbz_pend_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;
  logic [2*WIDTH-1:0] z_r;

  logic             signed_mode_s;
  logic             dvs_zero_s;
  logic [WIDTH-1:0] dvd_abs_s;
  logic [WIDTH-1:0] dvs_abs_s;
  logic [WIDTH-1:0] a_next_s;
  logic [WIDTH-1:0] q_next_s;

`ifdef DIV_SIGNED_EN
  assign signed_mode_s = is_signed;
`else
  logic unused_is_signed_s;
  assign unused_is_signed_s = is_signed;
  assign signed_mode_s      = 1'b0;
`endif

  assign dvs_zero_s = (divisor == '0);
  assign dvd_abs_s  = (signed_mode_s && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_abs_s  = (signed_mode_s && divisor[WIDTH-1])  ? -divisor  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_r),
    .q      (q_r),
    .d      (d_r),
    .a_next (a_next_s),
    .q_next (q_next_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (dvs_zero_s) begin
            state_next_s = S_DONE;
          end else begin
            state_next_s = S_RUN;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (count_r <= COUNT_ONE) begin
          state_next_s = S_FIXUP;
        end else begin
          state_next_s = S_RUN;
        end
      end
      S_FIXUP: state_next_s = S_DONE;
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; results publish on leaving DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_r        <= '0;
      q_r        <= '0;
      d_r        <= '0;
      count_r    <= '0;
      dvd_neg_r  <= 1'b0;
      dvs_neg_r  <= 1'b0;
      dbz_pend_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      dbz_r      <= 1'b0;
      z_r        <= '0;
    end else begin
      busy_r <= (state_next_s != S_IDLE);
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            dvd_neg_r  <= signed_mode_s & dividend[WIDTH-1];
            dvs_neg_r  <= signed_mode_s & divisor[WIDTH-1];
            d_r        <= dvs_abs_s;
            count_r    <= COUNT_LOAD;
            dbz_pend_r <= dvs_zero_s;
            if (dvs_zero_s) begin
              a_r <= dividend;
              q_r <= {WIDTH{DBZ_QUOTIENT_BIT}};
            end else begin
              a_r <= '0;
              q_r <= dvd_abs_s;
            end
          end
        end
        S_RUN: begin
          a_r     <= a_next_s;
          q_r     <= q_next_s;
          count_r <= count_r - COUNT_ONE;
        end
        S_FIXUP: begin
          // Truncating division: quotient sign from both operands,
          // remainder sign follows the dividend.
          q_r <= (dvd_neg_r ^ dvs_neg_r) ? -q_r : q_r;
          a_r <= dvd_neg_r ? -a_r : a_r;
        end
        S_DONE: begin
          done_r <= 1'b1;
          dbz_r  <= dbz_pend_r;
          z_r    <= {a_r, q_r};
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign z           = z_r;

endmodule
